// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and helpers
//
// Purpose: common definitions for the PS/2 host transmit and keyboard receive
// paths.
// Contents:
//   ps2_tx_state_t   host transmitter FSM state encoding
//   PS2_CMD_*        host-to-keyboard command bytes
//   PS2_KEY_*        arrow-key scan codes (extended set 2, second byte)
//   us_to_cycles     microseconds -> system clock cycles
//   odd_parity       PS/2 frame parity bit for a data byte

package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_CLK,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] PS2_KEY_UP    = 8'h75;
    localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;
    localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;

    // Integer MHz only; sub-MHz remainders of the clock are dropped.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    // The frame carries an odd number of ones across data + parity.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop synchronizer with falling-edge detect
//
// Purpose: brings one raw PS/2 pin into the clk domain and flags its falling
// edges. Shared by the host transmitter and the keyboard receiver.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low
//   pin    in   raw asynchronous pin
//   level  out  synchronized pin level
//   fe     out  one-cycle pulse when the synchronized level goes 1 -> 0

module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fe
);

    logic meta;
    logic sync;
    logic prev;

    // Reset to 1: an idle PS/2 line is pulled high, so no false edge
    // appears when reset is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= pin;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign fe    = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Purpose: sends one byte to a PS/2 device: inhibits the clock, issues
// request-to-send, shifts d0..d7, odd parity and stop on device clock falling
// edges, then checks the device ACK bit.
// Optional feature macro: PS2_TX_TIMEOUT_EN adds start and transfer timeouts
// that end the transfer with tx_error.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low
//   tx_data     in   byte to send, captured on accept
//   tx_start    in   request, accepted while tx_busy is low
//   tx_busy     out  transfer in progress
//   tx_done     out  one-cycle pulse, byte ACKed
//   tx_error    out  one-cycle pulse, NACK or timeout
//   ps2_clk_in  in   raw PS2_CLK pin
//   ps2_dat_in  in   raw PS2_DAT pin
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned RTS_CYC     = us_to_cycles(CLK_FREQ_HZ, 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned START_CYC   = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned XFER_CYC    = us_to_cycles(CLK_FREQ_HZ, XFER_TIMEOUT_US);
`else
    localparam int unsigned unused_tmo_us = START_TIMEOUT_US + XFER_TIMEOUT_US;
`endif

    logic clk_level;
    logic clk_fe;
    logic dat_level;
    logic unused_dat_fe;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level),
        .fe    (clk_fe)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_dat_in),
        .level (dat_level),
        .fe    (unused_dat_fe)
    );

    ps2_tx_state_t state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          dat_oe_q, dat_oe_d;
`ifdef PS2_TX_TIMEOUT_EN
    logic [31:0]   tmo_q, tmo_d;
`endif

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        dat_oe_d  = dat_oe_q;
`ifdef PS2_TX_TIMEOUT_EN
        tmo_d     = tmo_q + 32'd1;
`endif

        case (state_q)
            IDLE: begin
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    byte_d   = tx_data;
                    parity_d = odd_parity(tx_data);
                    cnt_d    = '0;
                    state_d  = INHIBIT;
                end
            end

            INHIBIT: begin
                if (cnt_q == INHIBIT_CYC - 1) begin
                    cnt_d    = '0;
                    // Data goes low together with RTS entry: this is the
                    // start bit, held until the device's first falling edge.
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            RTS: begin
                if (cnt_q == RTS_CYC - 1) begin
                    bit_idx_d = '0;
                    state_d   = WAIT_CLK;
`ifdef PS2_TX_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            WAIT_CLK: begin
                if (clk_fe) begin
                    dat_oe_d  = ~byte_q[0];
                    bit_idx_d = 4'd1;
                    state_d   = DATA;
`ifdef PS2_TX_TIMEOUT_EN
                    tmo_d     = '0;
                end else if (tmo_q == START_CYC - 1) begin
                    dat_oe_d  = 1'b0;
                    state_d   = ERROR;
`endif
                end
            end

            // bit_idx counts falling edges already seen: 1..7 -> d1..d7,
            // 8 -> parity, 9 -> stop (line released).
            DATA: begin
                if (clk_fe) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < 4'd8) begin
                        dat_oe_d = ~byte_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
`ifdef PS2_TX_TIMEOUT_EN
                end else if (tmo_q == XFER_CYC - 1) begin
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
`endif
                end
            end

            ACK: begin
                if (clk_fe) begin
                    state_d = dat_level ? ERROR : WAIT_IDLE;
`ifdef PS2_TX_TIMEOUT_EN
                end else if (tmo_q == XFER_CYC - 1) begin
                    dat_oe_d = 1'b0;
                    state_d  = ERROR;
`endif
                end
            end

            // The device still holds data low after ACK; completion is
            // reported only once both lines are back to idle.
            WAIT_IDLE: begin
                if (clk_level && dat_level) begin
                    state_d = DONE;
                end
            end

            DONE, ERROR: begin
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            dat_oe_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            dat_oe_q  <= dat_oe_d;
`ifdef PS2_TX_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    assign tx_busy    = (state_q != IDLE);
    assign tx_done    = (state_q == DONE);
    assign tx_error   = (state_q == ERROR);
    assign ps2_clk_oe = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_dat_oe = dat_oe_q;

endmodule
